jtag_tap_ctrl: RTL

IEEE 1149.1 TAP controller for the DCD JTAG port. It runs the 16-state TAP FSM and issues the capture/shift/update strobes that sequence the 4-bit instruction register and the data registers. It decodes the latched instruction into DR select lines, holds the bypass register (and, optionally, the IDCODE register), and muxes all serial outputs onto TDO.

---
 rtl/jtag_pkg.sv | 57 +++++
 rtl/jtag_tap_fsm.sv | 57 +++++
 rtl/jtag_tap_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, instruction opcodes and next-state helper
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PA_DR  = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PA_IR  = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_e;

    // Opcodes shared with the IR block
    localparam logic [3:0] OP_EXTEST  = 4'b0000;
    localparam logic [3:0] OP_SAMPLE  = 4'b0001;
    localparam logic [3:0] OP_IDCODE  = 4'b0010;
    localparam logic [3:0] OP_USER    = 4'b1000;
    localparam logic [3:0] OP_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    localparam int          IR_LENGTH_DEF    = 4;
    localparam logic [31:0] IDCODE_VALUE_DEF = 32'h0000_0001;

    // IEEE 1149.1 TAP transition table
    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PA_DR;
            PA_DR:   return tms ? EX2_DR : PA_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PA_IR;
            PA_IR:   return tms ? EX2_IR : PA_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            UPD_IR:  return tms ? SEL_DR : RTI;
            default: return TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP state machine with state strobe decodes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic state_tlr,
    output logic state_rti,
    output logic state_capture_ir,
    output logic state_shift_ir,
    output logic state_update_ir,
    output logic state_capture_dr,
    output logic state_shift_dr,
    output logic state_update_dr
);

    tap_state_e state_q;
    tap_state_e state_next;

    // State register, trst forces Test-Logic-Reset without a clock
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state and one-hot strobe decode of the current state
    always_comb begin
        state_next       = state_q;
        state_tlr        = 1'b0;
        state_rti        = 1'b0;
        state_capture_ir = 1'b0;
        state_shift_ir   = 1'b0;
        state_update_ir  = 1'b0;
        state_capture_dr = 1'b0;
        state_shift_dr   = 1'b0;
        state_update_dr  = 1'b0;

        state_next = tap_next(state_q, tms);

        case (state_q)
            TLR:     state_tlr        = 1'b1;
            RTI:     state_rti        = 1'b1;
            CAP_IR:  state_capture_ir = 1'b1;
            SH_IR:   state_shift_ir   = 1'b1;
            UPD_IR:  state_update_ir  = 1'b1;
            CAP_DR:  state_capture_dr = 1'b1;
            SH_DR:   state_shift_dr   = 1'b1;
            UPD_DR:  state_update_dr  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - TAP controller: FSM, instruction decode, bypass/idcode, TDO mux (option JTAG_IDCODE_REG_EN)
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_LENGTH    = IR_LENGTH_DEF,
    parameter logic [31:0] IDCODE_VALUE = IDCODE_VALUE_DEF
) (
    input  logic                 tck,
    input  logic                 trst,
    input  logic                 tms,
    input  logic                 tdi,
    input  logic [IR_LENGTH-1:0] latched_ir,
    input  logic                 ir_serout,
    input  logic                 dr_serout,
    output logic                 state_tlr,
    output logic                 state_rti,
    output logic                 state_capture_ir,
    output logic                 state_shift_ir,
    output logic                 state_update_ir,
    output logic                 state_capture_dr,
    output logic                 state_shift_dr,
    output logic                 state_update_dr,
    output logic                 sel_extest,
    output logic                 sel_sample,
    output logic                 sel_user,
    output logic                 sel_idcode,
    output logic                 sel_bypass,
    output logic                 tdo,
    output logic                 tdo_oe
);

    logic bypass_q;
    logic bypass_en;
    logic dr_tdo;

    jtag_tap_fsm u_fsm (
        .tck              (tck),
        .trst             (trst),
        .tms              (tms),
        .state_tlr        (state_tlr),
        .state_rti        (state_rti),
        .state_capture_ir (state_capture_ir),
        .state_shift_ir   (state_shift_ir),
        .state_update_ir  (state_update_ir),
        .state_capture_dr (state_capture_dr),
        .state_shift_dr   (state_shift_dr),
        .state_update_dr  (state_update_dr)
    );

    // One-hot DR select; unknown opcodes fall back to bypass
    always_comb begin
        sel_extest = 1'b0;
        sel_sample = 1'b0;
        sel_user   = 1'b0;
        sel_idcode = 1'b0;
        sel_bypass = 1'b0;
        case (latched_ir)
            IR_LENGTH'(OP_EXTEST): sel_extest = 1'b1;
            IR_LENGTH'(OP_SAMPLE): sel_sample = 1'b1;
            IR_LENGTH'(OP_IDCODE): sel_idcode = 1'b1;
            IR_LENGTH'(OP_USER):   sel_user   = 1'b1;
            IR_LENGTH'(OP_BYPASS): sel_bypass = 1'b1;
            default:               sel_bypass = 1'b1;
        endcase
    end

`ifdef JTAG_IDCODE_REG_EN
    logic [31:0] idcode_q;

    assign bypass_en = sel_bypass;

    // IDCODE shift register: load device ID on capture, shift right with tdi into bit31
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            idcode_q <= IDCODE_VALUE;
        end else if (state_capture_dr && sel_idcode) begin
            idcode_q <= IDCODE_VALUE;
        end else if (state_shift_dr && sel_idcode) begin
            idcode_q <= {tdi, idcode_q[31:1]};
        end
    end

    // Serial source for the DR path
    always_comb begin
        dr_tdo = dr_serout;
        if (bypass_en) begin
            dr_tdo = bypass_q;
        end else if (sel_idcode) begin
            dr_tdo = idcode_q[0];
        end
    end
`else
    logic unused_idcode;

    // Without the IDCODE register the IDCODE instruction rides on the bypass bit
    assign bypass_en     = sel_bypass | sel_idcode;
    assign unused_idcode = ^IDCODE_VALUE;

    // Serial source for the DR path
    always_comb begin
        dr_tdo = dr_serout;
        if (bypass_en) begin
            dr_tdo = bypass_q;
        end
    end
`endif

    // Single-bit bypass register: captures 0, then shifts tdi
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            bypass_q <= 1'b0;
        end else if (state_capture_dr && bypass_en) begin
            bypass_q <= 1'b0;
        end else if (state_shift_dr && bypass_en) begin
            bypass_q <= tdi;
        end
    end

    // TDO launched on the falling edge so the probe samples it mid-cycle
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_oe <= 1'b0;
        end else begin
            tdo_oe <= state_shift_ir | state_shift_dr;
            if (state_shift_ir) begin
                tdo <= ir_serout;
            end else if (state_shift_dr) begin
                tdo <= dr_tdo;
            end
        end
    end

endmodule
